pulse_window_counter: RTL and testbench

Counts debounced rising edges of an asynchronous energy-meter pulse input over windows delimited by a periodic window strobe from the one-second tick generator. At each window boundary it latches the accumulated count, presents it on a valid/ack interface, and restarts counting. It sits between the meter pulse pin and the supervision logic that converts pulses-per-window into power.

---
 rtl/pulse_window_counter_pkg.sv | 11 +
 rtl/pulse_debouncer.sv | 56 +++++
 rtl/pulse_window_counter.sv | 91 +++++++++
 tb/tb_pulse_window_counter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_window_counter_pkg.sv
// Shared helpers for the pulse window counter and its debouncer.
package pulse_window_counter_pkg;

    // Width of a counter that must hold values 0 .. n-1; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_debouncer.sv
// Synchronizes an asynchronous level, debounces it and emits a one-cycle
// event on each accepted 0->1 transition. Reusable for any meter input.
module pulse_debouncer
    import pulse_window_counter_pkg::*;
#(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic PulseIn,
    output logic PulseEvent
);

    localparam int CntW = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  synced;
    logic [CntW-1:0]       stable_cnt;
    logic                  level;

    assign synced = sync_q[SyncStages-1];

    // Synchronizer chain: shift the raw pin in one stage per clock.
    // NOTE: every flop here, sync chain included, is asynchronously reset so no X reaches the event logic.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge value.
            sync_q <= {sync_q[SyncStages-2:0], PulseIn};
        end
    end

    // Stability counter and debounced level; a matching sample restarts the count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stable_cnt <= '0;
            level      <= 1'b0;
            PulseEvent <= 1'b0;
        end else begin
            PulseEvent <= 1'b0;
            if (synced == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CntLast) begin
                level      <= synced;
                stable_cnt <= '0;
                PulseEvent <= synced;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_window_counter.sv
// Counts debounced meter pulses per window, latches the count on each
// WindowTick rising edge and offers it on a valid/ack interface.
module pulse_window_counter #(
    parameter int CountWidth     = 16,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  WindowTick,
    input  logic                  PulseIn,
    output logic [CountWidth-1:0] Count,
    output logic                  CountValid,
    input  logic                  CountAck,
    output logic                  Overflow,
    output logic                  MissedWindow
);

    localparam logic [CountWidth-1:0] AccMax = '1;

    logic                  pulse_event;
    logic                  tick_q;
    logic                  window_event;
    logic [CountWidth-1:0] acc;
    logic                  ovf_acc;
    logic                  acc_full;
    logic [CountWidth-1:0] closing_count;
    logic                  closing_ovf;

    pulse_debouncer #(
        .SyncStages     (SyncStages),
        .DebounceCycles (DebounceCycles)
    ) u_debouncer (
        .Clk        (Clk),
        .Reset      (Reset),
        .PulseIn    (PulseIn),
        .PulseEvent (pulse_event)
    );

    // A pulse arriving on the closing edge belongs to the closing window.
    assign window_event  = WindowTick & ~tick_q;
    assign acc_full      = (acc == AccMax);
    assign closing_count = acc_full ? acc : acc + CountWidth'(pulse_event);
    assign closing_ovf   = ovf_acc | (acc_full & pulse_event);

    // Registered WindowTick for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= WindowTick;
        end
    end

    // Saturating accumulator; cleared when a window closes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (window_event) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
        end else if (pulse_event) begin
            if (acc_full) begin
                ovf_acc <= 1'b1;
            end else begin
                acc <= acc + 1'b1;
            end
        end
    end

    // Result register, valid/ack handshake and sticky missed-window flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Count        <= '0;
            Overflow     <= 1'b0;
            CountValid   <= 1'b0;
            MissedWindow <= 1'b0;
        end else if (window_event) begin
            Count      <= closing_count;
            Overflow   <= closing_ovf;
            CountValid <= 1'b1;
            if (CountValid && !CountAck) begin
                MissedWindow <= 1'b1;
            end
        end else if (CountValid && CountAck) begin
            CountValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench for pulse_window_counter: a 16-bit and a 4-bit instance
// share stimulus; a spec-level model is compared on every cycle and
// literal expectations pin the key results.
module tb_pulse_window_counter;

    localparam int S = 2;
    localparam int D = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        WindowTick = 1'b0;
    logic        PulseIn = 1'b0;
    logic        CountAck = 1'b0;
    logic [15:0] count16;
    logic [3:0]  count4;
    logic        valid16, valid4, ovf16, ovf4, missed16, missed4;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    pulse_window_counter #(.CountWidth(16), .SyncStages(S), .DebounceCycles(D)) u_dut16 (
        .Clk(Clk), .Reset(Reset), .WindowTick(WindowTick), .PulseIn(PulseIn),
        .Count(count16), .CountValid(valid16), .CountAck(CountAck),
        .Overflow(ovf16), .MissedWindow(missed16)
    );

    pulse_window_counter #(.CountWidth(4), .SyncStages(S), .DebounceCycles(D)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .WindowTick(WindowTick), .PulseIn(PulseIn),
        .Count(count4), .CountValid(valid4), .CountAck(CountAck),
        .Overflow(ovf4), .MissedWindow(missed4)
    );

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models the 16-bit instance, index 1 the 4-bit instance.
    int  maxv [2] = '{65535, 15};
    int  m_acc [2], m_cnt [2];
    bit  m_ovf [2], m_ovo [2], m_val [2], m_mis [2];
    bit  m_tick, m_deb, m_pend, wev, all_flip, v;
    bit  hist [$];
    int  n, idx, sum;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int w = 0; w < 2; w++) begin
                m_acc[w] = 0; m_cnt[w] = 0; m_ovf[w] = 0;
                m_ovo[w] = 0; m_val[w] = 0; m_mis[w] = 0;
            end
            m_tick = 0; m_deb = 0; m_pend = 0;
            hist.delete();
        end else begin
            wev    = WindowTick && !m_tick;
            m_tick = WindowTick;
            for (int w = 0; w < 2; w++) begin
                if (wev) begin
                    sum = m_acc[w] + int'(m_pend);
                    if (sum > maxv[w]) begin
                        m_cnt[w] = maxv[w];
                        m_ovo[w] = 1;
                    end else begin
                        m_cnt[w] = sum;
                        m_ovo[w] = m_ovf[w];
                    end
                    if (m_val[w] && !CountAck) m_mis[w] = 1;
                    m_val[w] = 1;
                    m_acc[w] = 0;
                    m_ovf[w] = 0;
                end else begin
                    if (m_pend) begin
                        if (m_acc[w] == maxv[w]) m_ovf[w] = 1;
                        else m_acc[w] = m_acc[w] + 1;
                    end
                    if (m_val[w] && CountAck) m_val[w] = 0;
                end
            end
            // Debounced level flips once the last D synchronized samples
            // (raw samples delayed by S clocks) all disagree with it.
            n = hist.size();
            all_flip = 1;
            for (int i = 0; i < D; i++) begin
                idx = n - S - i;
                v = (idx >= 0) ? hist[idx] : 1'b0;
                if (v == m_deb) all_flip = 0;
            end
            m_pend = 0;
            if (all_flip) begin
                m_deb  = !m_deb;
                m_pend = m_deb;
            end
            hist.push_back(PulseIn);
            if (hist.size() > S + D + 4) void'(hist.pop_front());
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge Clk) begin
        check("count16",  int'(count16),  m_cnt[0]);
        check("valid16",  int'(valid16),  int'(m_val[0]));
        check("ovf16",    int'(ovf16),    int'(m_ovo[0]));
        check("missed16", int'(missed16), int'(m_mis[0]));
        check("count4",   int'(count4),   m_cnt[1]);
        check("valid4",   int'(valid4),   int'(m_val[1]));
        check("ovf4",     int'(ovf4),     int'(m_ovo[1]));
        check("missed4",  int'(missed4),  int'(m_mis[1]));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n_cyc);
        repeat (n_cyc) @(posedge Clk);
        #1;
    endtask

    task automatic pulses(input int n_p);
        repeat (n_p) begin
            PulseIn = 1'b1; step(10);
            PulseIn = 1'b0; step(10);
        end
    endtask

    task automatic ack_result(input string name);
        CountAck = 1'b1; step(1);
        CountAck = 1'b0;
        check({name, "_ack_valid"}, int'(valid16), 0);
    endtask

    // Raise WindowTick (optionally with an ack), check the latched result one cycle later.
    task automatic close_window(input string name, input int hold, input bit with_ack,
                                input int e16, input int e4, input bit eo16, input bit eo4,
                                input bit emiss);
        WindowTick = 1'b1;
        CountAck   = with_ack;
        step(1);
        CountAck = 1'b0;
        check({name, "_count16"}, int'(count16), e16);
        check({name, "_count4"},  int'(count4),  e4);
        check({name, "_ovf16"},   int'(ovf16),   int'(eo16));
        check({name, "_ovf4"},    int'(ovf4),    int'(eo4));
        check({name, "_valid"},   int'(valid16), 1);
        check({name, "_missed"},  int'(missed16), int'(emiss));
        if (hold > 1) step(hold - 1);
        WindowTick = 1'b0;
        step(1);
        check({name, "_held"}, int'(count16), e16);
    endtask

    initial begin
        step(3);
        check("rst_count", int'(count16), 0);
        check("rst_valid", int'(valid16), 0);
        check("rst_ovf",   int'(ovf16),   0);
        check("rst_missed", int'(missed16), 0);
        Reset = 1'b1;
        step(2);

        // Clean pulses, tick held high for 8 cycles.
        pulses(5);
        close_window("clean", 8, 1'b0, 5, 5, 0, 0, 0);
        ack_result("clean");

        // 2-cycle glitches are rejected, 3 real pulses counted.
        repeat (3) begin
            PulseIn = 1'b1; step(2);
            PulseIn = 1'b0; step(6);
        end
        pulses(3);
        close_window("glitch", 1, 1'b0, 3, 3, 0, 0, 0);
        ack_result("glitch");

        // 20 pulses saturate the 4-bit instance only; next window is clean.
        pulses(20);
        close_window("sat", 2, 1'b0, 20, 15, 0, 1, 0);
        ack_result("sat");
        pulses(2);
        close_window("after_sat", 2, 1'b0, 2, 2, 0, 0, 0);
        ack_result("after_sat");

        // Fifth pulse event lands on the window edge and is counted in it.
        pulses(4);
        PulseIn = 1'b1; step(6);
        close_window("coincide", 2, 1'b0, 5, 5, 0, 0, 0);
        step(1);
        PulseIn = 1'b0; step(10);
        // Next window starts from 0; ack with the closing edge is no miss.
        pulses(1);
        close_window("ack_tick", 1, 1'b1, 1, 1, 0, 0, 0);
        ack_result("ack_tick");

        // Two windows without ack: second overwrites, miss is sticky.
        pulses(3);
        close_window("miss_a", 1, 1'b0, 3, 3, 0, 0, 0);
        pulses(7);
        close_window("miss_b", 1, 1'b0, 7, 7, 0, 0, 1);
        ack_result("miss");
        check("miss_sticky", int'(missed16), 1);

        // Reset mid-window with a pending result and Acc=6.
        pulses(2);
        close_window("pre_rst", 1, 1'b0, 2, 2, 0, 0, 1);
        pulses(6);
        #3;
        Reset = 1'b0;
        #1;
        check("arst_count",  int'(count16),  0);
        check("arst_valid",  int'(valid16),  0);
        check("arst_missed", int'(missed16), 0);
        check("arst_ovf4",   int'(ovf4),     0);
        step(3);
        Reset = 1'b1;
        step(2);
        pulses(2);
        close_window("post_rst", 1, 1'b0, 2, 2, 0, 0, 0);
        ack_result("post_rst");
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
